// File: rtl/upload_pkg.sv
// Shared types for the upload framer: header defaults, arbiter states, frame descriptor.
// No logic; no latency.
// No flow control.
package upload_pkg;

    localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT = 8'h44;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_SRC,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CKSUM
    } arb_state_t;

    typedef struct packed {
        logic [7:0]  source;
        logic [15:0] len;
    } desc_t;

endpackage

// File: rtl/upload_chan_buf.sv
// Per-channel payload buffer: counts frame length and commits {source,len} descriptors.
// Latency: a descriptor is visible one clock after its commit edge.
// Backpressure: ready drops while either the payload or the descriptor FIFO is full.
module upload_chan_buf
    import upload_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int DESC_DEPTH  = 4,
    parameter int MAX_PAYLOAD = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [7:0] data,
    input  logic [7:0] source,
    input  logic       valid,
    output logic       ready,
    input  logic       pop_data,
    output logic [7:0] head_data,
    input  logic       pop_desc,
    output desc_t      head_desc,
    output logic       desc_vld
);

    localparam int            LW      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PAYLOAD);

    logic [LW-1:0] len_q;
    logic [LW-1:0] len_inc;
    logic [7:0]    src_q;
    logic [7:0]    src_cur;
    logic          req_d;
    logic          accept;
    logic          hit_max;
    logic          fell;
    logic          commit;
    logic          data_full;
    logic          data_empty;
    logic          desc_full;
    logic          desc_empty;
    desc_t         commit_desc;

    assign ready   = req && !data_full && !desc_full;
    assign accept  = req && valid && ready;
    assign len_inc = len_q + LW'(1);
    assign hit_max = accept && (len_inc == LEN_MAX);
    // Fall and accept are exclusive (accept needs req high), so one commit per cycle at most.
    assign fell    = req_d && !req && (len_q != '0);
    assign commit  = hit_max || fell;
    assign src_cur = (len_q == '0) ? source : src_q;

    assign commit_desc.source = src_cur;
    assign commit_desc.len    = 16'(hit_max ? len_inc : len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d <= 1'b0;
            len_q <= '0;
            src_q <= '0;
        end else begin
            req_d <= req;
            if (commit)      len_q <= '0;
            else if (accept) len_q <= len_inc;
            if (accept && (len_q == '0)) src_q <= source;
        end
    end

    upload_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_dat (data),
        .pop      (pop_data && !data_empty),
        .pop_dat  (head_data),
        .full     (data_full),
        .empty    (data_empty)
    );

    upload_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (commit),
        .push_dat (commit_desc),
        .pop      (pop_desc),
        .pop_dat  (head_desc),
        .full     (desc_full),
        .empty    (desc_empty)
    );

    assign desc_vld = !desc_empty;

endmodule

// File: rtl/upload_fifo.sv
// Generic first-word-fall-through FIFO; DEPTH must be a power of two, at least 2.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full or pop when empty.
module upload_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rptr[AW-1:0]];
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/upload_frame_arbiter.sv
// Round-robin merger of committed per-channel frames onto one framed byte stream.
// Latency: first header byte valid one clock after a descriptor is visible in IDLE; 1 byte/clk.
// Backpressure: output byte held stable while valid & ~ready; inputs stall only on full buffers.
module upload_frame_arbiter
    import upload_pkg::*;
#(
    parameter int         NUM_CHANNELS = 4,
    parameter int         FIFO_DEPTH   = 64,
    parameter int         DESC_DEPTH   = 4,
    parameter int         MAX_PAYLOAD  = 32,
    parameter logic [7:0] HDR0         = HDR0_DEFAULT,
    parameter logic [7:0] HDR1         = HDR1_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS-1:0]   raw_upload_req,
    input  logic [NUM_CHANNELS*8-1:0] raw_upload_data,
    input  logic [NUM_CHANNELS*8-1:0] raw_upload_source,
    input  logic [NUM_CHANNELS-1:0]   raw_upload_valid,
    output logic [NUM_CHANNELS-1:0]   raw_upload_ready,
    output logic                      merged_upload_req,
    output logic [7:0]                merged_upload_data,
    output logic [7:0]                merged_upload_source,
    output logic                      merged_upload_valid,
    input  logic                      merged_upload_ready
);

    localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           grant_nxt;
    logic [GW-1:0]           rr_ptr;
    logic [GW-1:0]           idx;
    logic                    found;
    desc_t                   cur_desc;
    logic [15:0]             cnt;
    logic [7:0]              cksum;
    logic [7:0]              byte_out;
    logic                    out_fire;
    logic [7:0]              ch_data [NUM_CHANNELS];
    desc_t                   ch_desc [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_vld;
    logic [NUM_CHANNELS-1:0] pop_data;
    logic [NUM_CHANNELS-1:0] pop_desc;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        upload_chan_buf #(
            .FIFO_DEPTH  (FIFO_DEPTH),
            .DESC_DEPTH  (DESC_DEPTH),
            .MAX_PAYLOAD (MAX_PAYLOAD)
        ) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (raw_upload_req[i]),
            .data      (raw_upload_data[8*i +: 8]),
            .source    (raw_upload_source[8*i +: 8]),
            .valid     (raw_upload_valid[i]),
            .ready     (raw_upload_ready[i]),
            .pop_data  (pop_data[i]),
            .head_data (ch_data[i]),
            .pop_desc  (pop_desc[i]),
            .head_desc (ch_desc[i]),
            .desc_vld  (ch_vld[i])
        );
    end

    // First channel holding a committed frame, searching upward from rr_ptr with wrap.
    always_comb begin
        found     = 1'b0;
        grant_nxt = rr_ptr;
        idx       = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = GW'((int'(rr_ptr) + k) % NUM_CHANNELS);
            if (!found && ch_vld[idx]) begin
                found     = 1'b1;
                grant_nxt = idx;
            end
        end
    end

    assign out_fire = (state != ST_IDLE) && merged_upload_ready;

    always_comb begin
        state_nxt = state;
        byte_out  = '0;
        pop_data  = '0;
        pop_desc  = '0;
        case (state)
            ST_IDLE:  if (found) state_nxt = ST_HDR0;
            ST_HDR0: begin
                byte_out = HDR0;
                if (out_fire) state_nxt = ST_HDR1;
            end
            ST_HDR1: begin
                byte_out = HDR1;
                if (out_fire) state_nxt = ST_SRC;
            end
            ST_SRC: begin
                byte_out = cur_desc.source;
                if (out_fire) state_nxt = ST_LEN_H;
            end
            ST_LEN_H: begin
                byte_out = cur_desc.len[15:8];
                if (out_fire) state_nxt = ST_LEN_L;
            end
            ST_LEN_L: begin
                byte_out = cur_desc.len[7:0];
                if (out_fire) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                byte_out = ch_data[grant];
                if (out_fire) begin
                    pop_data[grant] = 1'b1;
                    if (cnt == cur_desc.len - 16'd1) state_nxt = ST_CKSUM;
                end
            end
            ST_CKSUM: begin
                byte_out = cksum;
                if (out_fire) begin
                    pop_desc[grant] = 1'b1;
                    state_nxt       = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            cur_desc <= '0;
            cnt      <= '0;
            cksum    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                cnt   <= '0;
                cksum <= '0;
                if (found) begin
                    grant    <= grant_nxt;
                    cur_desc <= ch_desc[grant_nxt];
                end
            end else if (out_fire) begin
                if (state inside {ST_SRC, ST_LEN_H, ST_LEN_L, ST_DATA}) cksum <= cksum + byte_out;
                if (state == ST_DATA) cnt <= cnt + 16'd1;
                if (state == ST_CKSUM)
                    rr_ptr <= (int'(grant) == NUM_CHANNELS - 1) ? '0 : grant + GW'(1);
            end
        end
    end

    assign merged_upload_req    = (state != ST_IDLE);
    assign merged_upload_valid  = (state != ST_IDLE);
    assign merged_upload_data   = byte_out;
    assign merged_upload_source = (state != ST_IDLE) ? cur_desc.source : 8'h00;

endmodule

// File: tb/tb_upload_frame_arbiter.sv
// Bench for upload_frame_arbiter: queue-based frame model plus literal frame checks.
module tb_upload_frame_arbiter;

    localparam int NCH  = 4;
    localparam int MAXP = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NCH-1:0]   raw_upload_req, raw_upload_valid, raw_upload_ready;
    logic [NCH*8-1:0] raw_upload_data, raw_upload_source;
    logic             merged_upload_req, merged_upload_valid, merged_upload_ready;
    logic [7:0]       merged_upload_data, merged_upload_source;

    logic       c_req [NCH];
    logic       c_vld [NCH];
    logic [7:0] c_dat [NCH];
    logic [7:0] c_src [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_drv
        assign raw_upload_req[g]            = c_req[g];
        assign raw_upload_valid[g]          = c_vld[g];
        assign raw_upload_data[8*g +: 8]    = c_dat[g];
        assign raw_upload_source[8*g +: 8]  = c_src[g];
    end

    upload_frame_arbiter dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .raw_upload_req       (raw_upload_req),
        .raw_upload_data      (raw_upload_data),
        .raw_upload_source    (raw_upload_source),
        .raw_upload_valid     (raw_upload_valid),
        .raw_upload_ready     (raw_upload_ready),
        .merged_upload_req    (merged_upload_req),
        .merged_upload_data   (merged_upload_data),
        .merged_upload_source (merged_upload_source),
        .merged_upload_valid  (merged_upload_valid),
        .merged_upload_ready  (merged_upload_ready)
    );

    // Second instance with a tiny MAX_PAYLOAD to exercise the forced split.
    logic [3:0]  r4_req, r4_vld, r4_rdy;
    logic [31:0] r4_dat, r4_src;
    logic        m4_req, m4_vld, m4_rdy;
    logic [7:0]  m4_dat, m4_src;
    logic [7:0]  q4[$];

    upload_frame_arbiter #(.MAX_PAYLOAD(4)) dut4 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .raw_upload_req       (r4_req),
        .raw_upload_data      (r4_dat),
        .raw_upload_source    (r4_src),
        .raw_upload_valid     (r4_vld),
        .raw_upload_ready     (r4_rdy),
        .merged_upload_req    (m4_req),
        .merged_upload_data   (m4_dat),
        .merged_upload_source (m4_src),
        .merged_upload_valid  (m4_vld),
        .merged_upload_ready  (m4_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model: expected frames per channel ----------------
    logic [7:0] exp_bytes [NCH][$];
    int         exp_len   [NCH][$];
    logic [7:0] open_pay  [NCH][$];
    logic [7:0] open_src  [NCH];
    int         model_rr = 0;

    task automatic model_close(input int ch);
        int n;
        logic [7:0] ck;
        n = open_pay[ch].size();
        if (n == 0) return;
        ck = open_src[ch] + 8'(n >> 8) + 8'(n);
        exp_bytes[ch].push_back(8'hAA);
        exp_bytes[ch].push_back(8'h44);
        exp_bytes[ch].push_back(open_src[ch]);
        exp_bytes[ch].push_back(8'(n >> 8));
        exp_bytes[ch].push_back(8'(n));
        foreach (open_pay[ch][i]) begin
            exp_bytes[ch].push_back(open_pay[ch][i]);
            ck = ck + open_pay[ch][i];
        end
        exp_bytes[ch].push_back(ck);
        exp_len[ch].push_back(n + 6);
        open_pay[ch].delete();
    endtask

    task automatic model_accept(input int ch, input logic [7:0] b);
        if (open_pay[ch].size() == 0) open_src[ch] = c_src[ch];
        open_pay[ch].push_back(b);
        if (open_pay[ch].size() == MAXP) model_close(ch);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            exp_bytes[ch].delete();
            exp_len[ch].delete();
            open_pay[ch].delete();
        end
        model_rr = 0;
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int ch = 0; ch < NCH; ch++) s += exp_len[ch].size();
        return s;
    endfunction

    // ---------------- output checker ----------------
    int         pos = 0;
    int         cur_ch = -1;
    int         pick;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat, prev_srcv;
    logic [7:0] got_log[$];
    logic [7:0] lit[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            pos        = 0;
            prev_stall = 1'b0;
        end else if (merged_upload_valid) begin
            check_int("req_with_valid", int'(merged_upload_req), 1);
            if (prev_stall) begin
                check_int("stall_data", int'(merged_upload_data), int'(prev_dat));
                check_int("stall_src", int'(merged_upload_source), int'(prev_srcv));
            end
            if (merged_upload_ready) begin
                if (pos == 0) begin
                    cur_ch = -1;
                    for (int k = 0; k < NCH; k++) begin
                        pick = (model_rr + k) % NCH;
                        if (cur_ch < 0 && exp_len[pick].size() > 0) cur_ch = pick;
                    end
                end
                if (cur_ch < 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %02h with no frame expected at %0t",
                             merged_upload_data, $time);
                end else begin
                    check_int("stream_data", int'(merged_upload_data), int'(exp_bytes[cur_ch][pos]));
                    check_int("stream_src", int'(merged_upload_source), int'(exp_bytes[cur_ch][2]));
                    got_log.push_back(merged_upload_data);
                    pos++;
                    if (pos == exp_len[cur_ch][0]) begin
                        repeat (pos) void'(exp_bytes[cur_ch].pop_front());
                        void'(exp_len[cur_ch].pop_front());
                        model_rr = (cur_ch + 1) % NCH;
                        pos = 0;
                    end
                end
            end
            prev_stall = !merged_upload_ready;
            prev_dat   = merged_upload_data;
            prev_srcv  = merged_upload_source;
        end else begin
            if (prev_stall) check_int("valid_held_while_stalled", 0, 1);
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m4_vld) begin
            q4.push_back(m4_dat);
            check_int("t3_src", int'(m4_src), 8'h07);
            check_int("t3_req", int'(m4_req), 1);
        end
    end

    // ---------------- downstream ready driver ----------------
    logic rand_rdy  = 1'b0;
    logic rdy_fixed = 1'b1;
    initial merged_upload_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        merged_upload_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
    assign m4_rdy = 1'b1;

    // ---------------- stimulus helpers (all return at a falling edge) ----------------
    task automatic send_byte(input int ch, input logic [7:0] b, input int budget, output bit ok);
        ok = 1'b0;
        c_dat[ch] = b;
        c_vld[ch] = 1'b1;
        for (int t = 0; t < budget; t++) begin
            #1;
            if (raw_upload_ready[ch]) begin
                @(posedge clk);
                model_accept(ch, b);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        c_vld[ch] = 1'b0;
    endtask

    task automatic send_frame(input int ch, input logic [7:0] src, input logic [7:0] first,
                              input int n, input bit close);
        bit ok;
        c_src[ch] = src;
        c_req[ch] = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_byte(ch, first + 8'(i), 40, ok);
            if (!ok) fail_now("send_byte");
        end
        if (close) begin
            c_req[ch] = 1'b0;
            model_close(ch);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        int t;
        done = 1'b0;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            #2;
            done = (pending() == 0) && (pos == 0) && !merged_upload_valid;
            t++;
        end
        if (!done) fail_now(name);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_log(input string name);
        check_int({name, "_len"}, got_log.size(), lit.size());
        for (int i = 0; i < lit.size() && i < got_log.size(); i++)
            check_int(name, int'(got_log[i]), int'(lit[i]));
        got_log.delete();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_log.delete();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int acc;
        int t;
        int vcount;
        rst_n  = 1'b0;
        r4_req = '0; r4_vld = '0; r4_dat = '0; r4_src = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            c_req[ch] = 1'b0; c_vld[ch] = 1'b0; c_dat[ch] = '0; c_src[ch] = '0;
        end
        repeat (3) @(negedge clk);
        check_int("rst_merged_req", int'(merged_upload_req), 0);
        check_int("rst_merged_valid", int'(merged_upload_valid), 0);
        check_int("rst_merged_data", int'(merged_upload_data), 0);
        check_int("rst_merged_src", int'(merged_upload_source), 0);
        check_int("rst_raw_ready", int'(raw_upload_ready), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single frame on ch0
        send_frame(0, 8'h01, 8'hA1, 3, 1'b1);
        wait_idle("t1_drain");
        lit = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hEA};
        check_log("t1_frame");

        // 4: same frame under random downstream stalls
        rand_rdy = 1'b1;
        send_frame(0, 8'h01, 8'hA1, 3, 1'b1);
        wait_idle("t4_drain");
        rand_rdy = 1'b0;
        check_log("t4_frame");

        // 2: two channels closing together, served ch0 then ch1 from a fresh pointer
        reset_pulse();
        fork
            send_frame(0, 8'h01, 8'hC0, 2, 1'b1);
            send_frame(1, 8'h03, 8'hD0, 2, 1'b1);
        join
        wait_idle("t2_drain");
        lit = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h02, 8'hC0, 8'hC1, 8'h84,
                8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'hD0, 8'hD1, 8'hA6};
        check_log("t2_frames");

        // 5a: downstream blocked, payload FIFO fills at 64 bytes
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        c_src[0] = 8'h20;
        c_req[0] = 1'b1;
        acc = 0;
        for (int i = 0; i < 70; i++) begin
            send_byte(0, 8'(i), 8, ok);
            if (!ok) break;
            acc++;
        end
        check_int("t5_bytes_before_stall", acc, 64);
        #1;
        check_int("t5_ready_low_data_full", int'(raw_upload_ready[0]), 0);
        c_req[0] = 1'b0;
        model_close(0);
        @(negedge clk);
        rdy_fixed = 1'b1;
        wait_idle("t5a_drain");
        check_int("t5a_bytes_out", got_log.size(), 2 * (MAXP + 6));
        got_log.delete();

        // 5b: downstream blocked, descriptor FIFO fills at 4 frames
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) send_frame(0, 8'h30 + 8'(k), 8'h50 + 8'(k), 1, 1'b1);
        c_req[0] = 1'b1;
        #1;
        check_int("t5_ready_low_desc_full", int'(raw_upload_ready[0]), 0);
        repeat (3) @(negedge clk);
        check_int("t5_ready_still_low", int'(raw_upload_ready[0]), 0);
        c_req[0] = 1'b0;
        @(negedge clk);
        rdy_fixed = 1'b1;
        wait_idle("t5b_drain");
        check_int("t5b_bytes_out", got_log.size(), 4 * 7);
        got_log.delete();

        // 6: reset in the middle of a payload with two channels pending
        fork
            send_frame(0, 8'h11, 8'h60, 8, 1'b1);
            send_frame(1, 8'h12, 8'h70, 8, 1'b1);
        join
        t = 0;
        while (pos < 7 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (pos < 7) fail_now("t6_reach_data");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_int("t6_rst_valid", int'(merged_upload_valid), 0);
        check_int("t6_rst_req", int'(merged_upload_req), 0);
        check_int("t6_rst_data", int'(merged_upload_data), 0);
        check_int("t6_rst_src", int'(merged_upload_source), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_log.delete();
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (merged_upload_valid) vcount++;
        end
        check_int("t6_no_residual", vcount, 0);
        send_frame(1, 8'h05, 8'h5A, 1, 1'b1);
        wait_idle("t6_drain");
        lit = '{8'hAA, 8'h44, 8'h05, 8'h00, 8'h01, 8'h5A, 8'h60};
        check_log("t6_frame");

        // 3: forced split at MAX_PAYLOAD=4 on the second instance, channel 2
        q4.delete();
        r4_src[23:16] = 8'h07;
        r4_req[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r4_dat[23:16] = 8'h10 + 8'(i);
            r4_vld[2] = 1'b1;
            t = 0;
            #1;
            while (!r4_rdy[2] && t < 20) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (!r4_rdy[2]) fail_now("t3_send");
            @(posedge clk);
            @(negedge clk);
        end
        r4_vld = '0;
        r4_req = '0;
        repeat (40) @(negedge clk);
        lit = '{8'hAA, 8'h44, 8'h07, 8'h00, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h51,
                8'hAA, 8'h44, 8'h07, 8'h00, 8'h02, 8'h14, 8'h15, 8'h32};
        check_int("t3_len", q4.size(), lit.size());
        for (int i = 0; i < lit.size() && i < q4.size(); i++)
            check_int("t3_bytes", int'(q4[i]), int'(lit[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
